// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding and
// requester/select sizing.
package rr_mux_arbiter_pkg;
  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant/output bundle of the round-robin mux arbiter.
interface rr_mux_arbiter_if;
  import rr_mux_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] data;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] gnt;
  logic             out_valid;
  logic             out_data;
  logic             busy;
  logic             timeout_err;

  modport master (
    output req, data, out_ready,
    input  sel, gnt, out_valid, out_data, busy, timeout_err
  );

  modport slave (
    input  req, data, out_ready,
    output sel, gnt, out_valid, out_data, busy, timeout_err
  );
endinterface

// File: rtl/rr_mux_arbiter_mux.sv
// 16:1 single-bit multiplexer used on the arbiter data path.
module mux_16x1 (
  input  logic [15:0] data,
  input  logic [3:0]  sel,
  output logic        y
);
  assign y = data[sel];
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over 16 requesters with a grant timeout; the granted
// requester's payload bit is routed out through a 16:1 mux.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  rr_mux_arbiter_if.slave   bus
);
  state_t           state, state_nx;
  logic [SEL_W-1:0] ptr, ptr_nx;
  logic [SEL_W-1:0] sel_q, sel_nx;
  logic [N_REQ-1:0] gnt_q, gnt_nx;
  logic             valid_q, valid_nx;
  logic             busy_q, busy_nx;
  logic             terr_q, terr_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] win;
  logic             xfer;

  // First requester strictly after p (wrapping); p itself is checked last.
  function automatic logic [SEL_W-1:0] find_winner(
    input logic [N_REQ-1:0] r,
    input logic [SEL_W-1:0] p
  );
    logic [SEL_W-1:0] idx;
    find_winner = p;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = p + SEL_W'(k);
      if (r[idx]) find_winner = idx;
    end
  endfunction

  // After a transfer the search starts from the requester just served.
  assign base = (state == GRANT) ? sel_q : ptr;
  assign win  = find_winner(bus.req, base);
  assign xfer = (state == GRANT) && valid_q && bus.out_ready;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel_q;
    gnt_nx   = gnt_q;
    valid_nx = valid_q;
    busy_nx  = busy_q;
    terr_nx  = 1'b0;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nx = GRANT;
          sel_nx   = win;
          gnt_nx   = N_REQ'(1) << win;
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
          cnt_nx   = '0;
        end else begin
          gnt_nx   = '0;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
        end
      end
      default: begin
        if (xfer) begin
          ptr_nx = sel_q;
          if (|bus.req) begin
            sel_nx = win;
            gnt_nx = N_REQ'(1) << win;
            cnt_nx = '0;
          end else begin
            state_nx = IDLE;
            gnt_nx   = '0;
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
          end
        end else if (!bus.req[sel_q] || cnt == 8'(TIMEOUT - 1)) begin
          // Withdrawn request leaves the pointer alone; a timeout skips it.
          if (bus.req[sel_q]) begin
            terr_nx = 1'b1;
            ptr_nx  = sel_q;
          end
          state_nx = IDLE;
          gnt_nx   = '0;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '1;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      sel_q   <= sel_nx;
      gnt_q   <= gnt_nx;
      valid_q <= valid_nx;
      busy_q  <= busy_nx;
      terr_q  <= terr_nx;
      cnt     <= cnt_nx;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.gnt         = gnt_q;
  assign bus.out_valid   = valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

  mux_16x1 u_mux (
    .data (bus.data),
    .sel  (sel_q),
    .y    (bus.out_data)
  );
endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8, range 1..255: cycles a grant may wait for out_ready before being dropped.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  16  per-requester request, level-sensitive.
REQ-005 data  input  16  per-requester 1-bit payload; data[i] belongs to requester i.
REQ-006 out_ready  input  1  downstream accepts out_data this cycle.
REQ-007 sel  output  4  index of the current/last granted requester (mux select).
REQ-008 gnt  output  16  one-hot grant, all-zero when no grant is active.
REQ-009 out_valid  output  1  out_data is valid for the granted requester.
REQ-010 out_data  output  1  data[sel], routed through the 16:1 mux.
REQ-011 busy  output  1  high while in GRANT state.
REQ-012 timeout_err  output  1  one-cycle pulse when a grant is dropped on timeout.

Function
REQ-013 The FSM SHALL have two states, IDLE and GRANT, with all outputs registered except out_data.
REQ-014 The winner SHALL be the first i with req[i]=1, searching (ptr+1) mod 16 upward with wrap; ptr is the last granted index.
REQ-015 In IDLE with any req set in cycle N, the block SHALL enter GRANT in N+1 with sel=winner, gnt=1<<winner, out_valid=1, busy=1.
REQ-016 In IDLE with req=0, the block SHALL stay in IDLE with gnt=0, out_valid=0 and sel holding its last value.
REQ-017 A transfer SHALL occur in any GRANT cycle where out_valid && out_ready; ptr SHALL then update to sel.
REQ-018 After a transfer, if any req is set (including the one just served), the block SHALL grant the new winner in the next cycle (back-to-back, no bubble); otherwise it SHALL enter IDLE.
REQ-019 If req[sel] drops while in GRANT without a transfer, the block SHALL go to IDLE next cycle, leaving ptr unchanged, with no error.
REQ-020 A wait counter SHALL reset to 0 on entry to GRANT and increment each GRANT cycle without a transfer.
REQ-021 When the counter reaches TIMEOUT-1 without a transfer, the next cycle SHALL have timeout_err=1 for one cycle, ptr=sel (requester skipped) and state IDLE.
REQ-022 If transfer and timeout coincide in the same cycle, the transfer SHALL win and no timeout_err SHALL be raised.
REQ-023 A lone requester holding req SHALL be re-granted every cycle it transfers, and SHALL be served at least once every 16 grants under full contention.
REQ-024 out_data SHALL equal data[sel] combinationally and is meaningful only while out_valid=1.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, ptr=15 (requester 0 has highest priority), sel=0, gnt=0, out_valid=0, busy=0, timeout_err=0, counter=0.
REQ-026 Reset asserted mid-grant SHALL abandon the grant with no transfer and no timeout_err.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE, GRANT), the requester count 16 and the select width 4.
REQ-028 The data path SHALL instantiate the team's existing mux_16x1 as the single sub-module, driven by sel; winner search is a local function.

Verification
REQ-029 After reset, req=16'h0001, out_ready=1 -> next cycle gnt=16'h0001, sel=0, out_valid=1; transfer in every following cycle.
REQ-030 req=16'hFFFF, out_ready=1 for 17 cycles -> sel sequence 0,1,...,15,0 with no idle cycles.
REQ-031 ptr=5, req=16'h0021 (bits 0 and 5) -> grant goes to 0, then 5 after its transfer.
REQ-032 Granted requester 3, out_ready=0 for TIMEOUT=8 cycles -> timeout_err pulses once, state IDLE, next winner searched from 4.
REQ-033 Requester 7 granted, req[7] drops before out_ready -> IDLE next cycle, no timeout_err, ptr unchanged; data[7]=1 seen on out_data while valid.
REQ-034 rst asserted during GRANT with out_ready=0 -> next cycle gnt=0, out_valid=0, sel=0, then requester 0 wins if requesting.
